// File: rtl/slot_gfx_pkg.sv
// Shared types and constants for the slot-machine graphics blocks.
// Reel renderers and the compositor use these to agree on pixel format and reel state.
package slot_gfx_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t KEY_RGB_DEFAULT = 16'hF81F;
  localparam rgb565_t BG_RGB_DEFAULT  = 16'h0000;

  localparam int unsigned SPRITE_DIM      = 16;
  localparam int unsigned SPRITE_DIM_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    ALIGN = 2'd2
  } reel_state_t;

  function automatic logic [3:0] offset_inc(input logic [3:0] value);
    return value + 4'd1;
  endfunction

endpackage

// File: rtl/reel_spin_ctrl.sv
// Reel spin controller: advances the vertical scroll offset once per frame
// and lands the reel on a symbol boundary after a stop request.
module reel_spin_ctrl
  import slot_gfx_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       spin_start,
  input  logic       stop_req,
  output logic [3:0] offset,
  output logic       busy,
  output logic       settled
);

  reel_state_t state_r;
  logic [3:0]  offset_r;
  logic        busy_r;
  logic        settled_r;
  logic [3:0]  offset_next_s;

  // Wrapped next scroll position, only committed on a frame tick.
  always_comb begin
    offset_next_s = offset_inc(offset_r);
  end

  // Spin FSM with registered offset, busy and settled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      offset_r  <= 4'd0;
      busy_r    <= 1'b0;
      settled_r <= 1'b0;
    end else begin
      settled_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (spin_start) begin
            state_r <= SPIN;
            busy_r  <= 1'b1;
          end
        end
        SPIN: begin
          if (frame_tick) begin
            offset_r <= offset_next_s;
          end
          // A boundary reached on the stop cycle itself does not land the reel.
          if (stop_req) begin
            state_r <= ALIGN;
          end
        end
        ALIGN: begin
          if (frame_tick) begin
            offset_r <= offset_next_s;
            if (offset_next_s == 4'd0) begin
              state_r   <= IDLE;
              busy_r    <= 1'b0;
              settled_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign offset  = offset_r;
  assign busy    = busy_r;
  assign settled = settled_r;

endmodule

// File: rtl/reel_sprite_reader.sv
// Reel window sprite reader: maps screen coordinates to sprite ROM addresses
// and returns colour-keyed pixels three cycles after they are presented.
module reel_sprite_reader
  import slot_gfx_pkg::*;
#(
  parameter logic [9:0]  X0         = 10'd288,
  parameter logic [9:0]  Y0         = 10'd208,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter rgb565_t     KEY_RGB    = KEY_RGB_DEFAULT,
  parameter rgb565_t     BG_RGB     = BG_RGB_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        px_valid,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic        frame_tick,
  input  logic        spin_start,
  input  logic        stop_req,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_rgb,
  output logic        out_valid,
  output logic        out_hit,
  output logic [15:0] out_rgb,
  output logic        busy,
  output logic        settled
);

  localparam logic [10:0] WIN_SIZE = 11'(SPRITE_DIM << SCALE_LOG2);

  logic [3:0]  offset_s;
  logic [10:0] dx_s;
  logic [10:0] dy_s;
  logic        in_win_s;
  logic [3:0]  col_s;
  logic [3:0]  row_s;
  logic [7:0]  addr_s;
  logic        hit_s;
  rgb565_t     rgb_s;

  logic [7:0]  rom_addr_r;
  logic        s1_valid_r;
  logic        s1_in_r;
  logic        s2_valid_r;
  logic        s2_in_r;
  logic        out_valid_r;
  logic        out_hit_r;
  rgb565_t     out_rgb_r;

  reel_spin_ctrl u_spin (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .spin_start (spin_start),
    .stop_req   (stop_req),
    .offset     (offset_s),
    .busy       (busy),
    .settled    (settled)
  );

  // Window membership via 11-bit differences: bit 10 is the borrow for coordinates left of/above the window.
  always_comb begin
    dx_s     = {1'b0, px_x} - {1'b0, X0};
    dy_s     = {1'b0, px_y} - {1'b0, Y0};
    in_win_s = px_valid && !dx_s[10] && !dy_s[10]
               && (dx_s < WIN_SIZE) && (dy_s < WIN_SIZE);
    col_s    = 4'(dx_s[9:0] >> SCALE_LOG2);
    row_s    = 4'(dy_s[9:0] >> SCALE_LOG2) + offset_s;
    if (in_win_s) begin
      addr_s = {row_s, col_s};
    end else begin
      addr_s = 8'h00;
    end
  end

  // Colour key applied to the ROM word aligned with stage-2 flags.
  always_comb begin
    hit_s = s2_in_r && (rom_rgb != KEY_RGB);
    if (hit_s) begin
      rgb_s = rom_rgb;
    end else begin
      rgb_s = BG_RGB;
    end
  end

  // Address register and flag pipeline that tracks the ROM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_r  <= 8'h00;
      s1_valid_r  <= 1'b0;
      s1_in_r     <= 1'b0;
      s2_valid_r  <= 1'b0;
      s2_in_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_hit_r   <= 1'b0;
      out_rgb_r   <= BG_RGB;
    end else begin
      rom_addr_r  <= addr_s;
      s1_valid_r  <= px_valid;
      s1_in_r     <= in_win_s;
      s2_valid_r  <= s1_valid_r;
      s2_in_r     <= s1_in_r;
      out_valid_r <= s2_valid_r;
      out_hit_r   <= hit_s;
      out_rgb_r   <= rgb_s;
    end
  end

  assign rom_addr  = rom_addr_r;
  assign out_valid = out_valid_r;
  assign out_hit   = out_hit_r;
  assign out_rgb   = out_rgb_r;

endmodule

// File: tb/tb_reel_sprite_reader.sv
// Scoreboard bench for reel_sprite_reader with a registered sprite ROM model.
module tb_reel_sprite_reader;
  import slot_gfx_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        px_valid = 1'b0;
  logic [9:0]  px_x = 10'd0;
  logic [9:0]  px_y = 10'd0;
  logic        frame_tick = 1'b0;
  logic        spin_start = 1'b0;
  logic        stop_req = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_rgb = 16'h0000;
  logic        out_valid;
  logic        out_hit;
  logic [15:0] out_rgb;
  logic        busy;
  logic        settled;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        hit;
    logic [15:0] rgb;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  reel_sprite_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .px_valid   (px_valid),
    .px_x       (px_x),
    .px_y       (px_y),
    .frame_tick (frame_tick),
    .spin_start (spin_start),
    .stop_req   (stop_req),
    .rom_addr   (rom_addr),
    .rom_rgb    (rom_rgb),
    .out_valid  (out_valid),
    .out_hit    (out_hit),
    .out_rgb    (out_rgb),
    .busy       (busy),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    if (a == 8'h12) return 16'hF81F;
    else if (a == 8'h13) return 16'h07E0;
    else return {a ^ 8'hA5, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_rgb <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_hit", 32'(out_hit), 32'(e.hit));
        chk("out_rgb", 32'(out_rgb), 32'(e.rgb));
        chk("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
  end

  task automatic px(input logic v, input int x, input int y,
                    input logic [7:0] exp_addr, input logic exp_in);
    exp_t e;
    logic [15:0] w;
    @(negedge clk);
    px_valid = v;
    px_x = 10'(x);
    px_y = 10'(y);
    if (v) begin
      w = rom_word(exp_addr);
      e.hit = exp_in && (w != 16'hF81F);
      e.rgb = e.hit ? w : 16'h0000;
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
  endtask

  task automatic idle();
    @(negedge clk);
    px_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic s, input logic p, input logic t,
                     input logic exp_settled, input logic exp_busy);
    @(negedge clk);
    spin_start = s;
    stop_req = p;
    frame_tick = t;
    @(posedge clk);
    #1;
    spin_start = 1'b0;
    stop_req = 1'b0;
    frame_tick = 1'b0;
    chk("settled", 32'(settled), 32'(exp_settled));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 32'h00);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_hit", 32'(out_hit), 32'd0);
    chk("reset_out_rgb", 32'(out_rgb), 32'h0000);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_settled", 32'(settled), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Window corners, edges, colour key, offset 0
    px(1'b1, 288, 208, 8'h00, 1'b1);
    px(1'b1, 351, 271, 8'hFF, 1'b1);
    px(1'b1, 352, 208, 8'h00, 1'b0);
    px(1'b1, 287, 208, 8'h00, 1'b0);
    px(1'b1, 296, 212, 8'h12, 1'b1);
    px(1'b1, 300, 212, 8'h13, 1'b1);
    px(1'b1, 288, 272, 8'h00, 1'b0);
    px(1'b1, 320, 240, 8'h88, 1'b1);
    px(1'b0, 300, 212, 8'h00, 1'b0);
    px(1'b1, 351, 208, 8'h0F, 1'b1);
    idle();

    // Spin: 17 ticks wrap offset to 1
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    px(1'b1, 288, 268, 8'h00, 1'b1);
    px(1'b1, 292, 208, 8'h11, 1'b1);
    idle();

    // Advance to offset 13, then stop: lands on the third tick
    for (int i = 0; i < 12; i++) ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    px(1'b1, 288, 208, 8'hD0, 1'b1);
    idle();
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(1'b1, 288, 208, 8'h00, 1'b1);
    px(1'b1, 288, 212, 8'h10, 1'b1);
    idle();
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    px(1'b1, 288, 212, 8'h10, 1'b1);
    idle();

    // Start+stop together spins only; stop+tick reaching 0 does not settle
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-ALIGN (offset 1) with pixels streaming
    px(1'b1, 288, 208, 8'h10, 1'b1);
    px(1'b1, 292, 212, 8'h21, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h00);
    chk("rst_offset", 32'(dut.offset_s), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    px_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    px(1'b1, 288, 208, 8'h00, 1'b1);
    px(1'b1, 296, 216, 8'h22, 1'b1);
    idle();
    chk("post_rst_busy", 32'(busy), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
